// File: rtl/pe_chain_sequencer.sv
// ---------------------------------------------------------------------------
// pe_chain_sequencer
//
// Controller for a 1-D weight-stationary chain of NUM_PE processing elements.
// Each PE registers x and forwards it. It also registers y_out = w*x + y_in.
// For each job the controller:
//   - optionally loads one weight into each PE;
//   - streams `len` samples into PE 0, with y seeded to 0;
//   - follows sample validity through the chain latency using a tag shift
//     register;
//   - qualifies the tail y as results;
//   - pulses done once the last result has left the chain.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start, load_w, len         job request; sampled only in IDLE
//   w_in_data/valid/ready      weight stream (accepted only in LOAD_W)
//   x_in_data/valid/ready      sample stream (accepted only in STREAM)
//   pe_w_data, pe_w_sel        registered weight value and one-hot PE write strobe
//   pe_x, pe_y                 registered x and y seed into PE 0
//   pe_y_tail                  y_out of the last PE
//   res_data, res_valid        result and qualifier (no backpressure)
//   busy, done                 status; done is a one-cycle completion pulse
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready depends only on state and counters, never on valid.
// Data is not required to stay stable while ready is low.
// ---------------------------------------------------------------------------
module pe_chain_sequencer #(
    parameter int DATA_W = 8,
    parameter int NUM_PE = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_w,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] w_in_data,
    input  logic              w_in_valid,
    output logic              w_in_ready,
    input  logic [DATA_W-1:0] x_in_data,
    input  logic              x_in_valid,
    output logic              x_in_ready,
    output logic [DATA_W-1:0] pe_w_data,
    output logic [NUM_PE-1:0] pe_w_sel,
    output logic [DATA_W-1:0] pe_x,
    output logic [DATA_W-1:0] pe_y,
    input  logic [DATA_W-1:0] pe_y_tail,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    output logic              busy,
    output logic              done
);

    localparam int WCNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   pe_w_data_q, pe_w_data_d;
    logic [NUM_PE-1:0]   pe_w_sel_q, pe_w_sel_d;
    logic [DATA_W-1:0]   pe_x_q, pe_x_d;
    logic [DATA_W-1:0]   pe_y_q;
    logic [NUM_PE:0]     tag_q;
    logic                tag_in;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_valid_q;

    logic w_accept;
    logic x_accept;
    logic w_last;

    assign w_in_ready = (state_q == LOAD_W);
    assign x_in_ready = (state_q == STREAM) && (cnt_q != '0);
    assign w_accept   = w_in_ready && w_in_valid;
    assign x_accept   = x_in_ready && x_in_valid;
    assign w_last     = (wcnt_q == WCNT_W'(NUM_PE - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        pe_w_data_d = pe_w_data_q;
        pe_w_sel_d  = '0;
        pe_x_d      = '0;      // bubble unless a sample is accepted
        tag_in      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    wcnt_d  = '0;
                    state_d = load_w ? LOAD_W : STREAM;
                end
            end
            LOAD_W: begin
                if (w_accept) begin
                    pe_w_data_d = w_in_data;
                    pe_w_sel_d  = NUM_PE'(1) << wcnt_q;
                    wcnt_d      = wcnt_q + 1'b1;
                    if (w_last) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;    // empty job: nothing to stream
                end else if (x_accept) begin
                    pe_x_d = x_in_data;
                    tag_in = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // All tags have reached res_valid once the pipeline is empty.
                if (tag_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            pe_w_data_q <= '0;
            pe_w_sel_q  <= '0;
            pe_x_q      <= '0;
            pe_y_q      <= '0;
            tag_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            pe_w_data_q <= pe_w_data_d;
            pe_w_sel_q  <= pe_w_sel_d;
            pe_x_q      <= pe_x_d;
            pe_y_q      <= '0;     // every job seeds the chain with y = 0
            // tag_q[k] matches the data k cycles past pe_x. tag_q[NUM_PE]
            // therefore lines up with pe_y_tail.
            tag_q       <= {tag_q[NUM_PE-1:0], tag_in};
            res_data_q  <= pe_y_tail;
            res_valid_q <= tag_q[NUM_PE];
        end
    end

    assign pe_w_data = pe_w_data_q;
    assign pe_w_sel  = pe_w_sel_q;
    assign pe_x      = pe_x_q;
    assign pe_y      = pe_y_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pe_chain_sequencer.sv
// Testbench for pe_chain_sequencer.
// A behavioural PE chain closes the loop around the DUT. Jobs come from a table
// of hand-computed results, and a negedge monitor scores each result against an
// expected queue of data and arrival cycle.
module tb_pe_chain_sequencer;
    localparam int DATA_W = 8;
    localparam int NUM_PE = 4;
    localparam int LEN_W  = 8;
    localparam int MAXS   = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              load_w;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] w_in_data;
    logic              w_in_valid;
    logic              w_in_ready;
    logic [DATA_W-1:0] x_in_data;
    logic              x_in_valid;
    logic              x_in_ready;
    logic [DATA_W-1:0] pe_w_data;
    logic [NUM_PE-1:0] pe_w_sel;
    logic [DATA_W-1:0] pe_x;
    logic [DATA_W-1:0] pe_y;
    logic [DATA_W-1:0] pe_y_tail;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              busy;
    logic              done;

    pe_chain_sequencer #(
        .DATA_W(DATA_W), .NUM_PE(NUM_PE), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .load_w(load_w), .len(len),
        .w_in_data(w_in_data), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .x_in_data(x_in_data), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
        .pe_w_data(pe_w_data), .pe_w_sel(pe_w_sel), .pe_x(pe_x), .pe_y(pe_y),
        .pe_y_tail(pe_y_tail), .res_data(res_data), .res_valid(res_valid),
        .busy(busy), .done(done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural PE chain ----------------
    logic [DATA_W-1:0] m_w [NUM_PE];
    logic [DATA_W-1:0] m_x [NUM_PE];
    logic [DATA_W-1:0] m_y [NUM_PE];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_w_sel[i]) m_w[i] <= pe_w_data;
        end
        m_x[0] <= pe_x;
        m_y[0] <= m_w[0] * pe_x + pe_y;
        for (int i = 1; i < NUM_PE; i++) begin
            m_x[i] <= m_x[i-1];
            m_y[i] <= m_w[i] * m_x[i-1] + m_y[i-1];
        end
    end
    assign pe_y_tail = m_y[NUM_PE-1];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_cyc_q[$];
    int res_cnt = 0;
    int done_cnt = 0;
    int last_res_cyc = 0;
    int done_cyc = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (res_valid) begin
            res_cnt++;
            last_res_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("res_unexpected_valid", int'(res_valid), 0);
            end else begin
                chk("res_data", int'(res_data), int'(exp_q.pop_front()));
                chk("res_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic                         load_w;
        int                           len;
        int                           gap;
        logic                         noise;
        logic [NUM_PE-1:0][DATA_W-1:0] w;
        logic [MAXS-1:0][DATA_W-1:0]   x;
        logic [MAXS-1:0][DATA_W-1:0]   e;
    } job_t;

    job_t jobs [6];

    task automatic run_job(input job_t j);
        exp_q.delete();
        exp_cyc_q.delete();
        res_cnt  = 0;
        done_cnt = 0;
        chk("idle_busy", int'(busy), 0);
        start  = 1'b1;
        load_w = j.load_w;
        len    = LEN_W'(j.len);
        tick();
        start  = 1'b0;
        load_w = 1'b0;
        len    = '0;
        chk("busy_rise", int'(busy), 1);
        if (j.load_w) begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (k > 0) begin
                    for (int g = 0; g < j.gap; g++) begin
                        tick();
                        chk("w_sel_no_accept", int'(pe_w_sel), 0);
                    end
                end
                w_in_data  = j.w[k];
                w_in_valid = 1'b1;
                chk("w_ready", int'(w_in_ready), 1);
                tick();
                w_in_valid = 1'b0;
                chk("w_sel_onehot", int'(pe_w_sel), 1 << k);
                chk("w_data", int'(pe_w_data), int'(j.w[k]));
            end
        end
        if (j.noise) begin
            start      = 1'b1;
            w_in_valid = 1'b1;
            w_in_data  = 8'hAA;
        end
        for (int s = 0; s < j.len; s++) begin
            if (s > 0) begin
                for (int g = 0; g < j.gap; g++) begin
                    chk("x_ready_gap", int'(x_in_ready), 1);
                    if (j.noise) chk("w_ready_stream", int'(w_in_ready), 0);
                    tick();
                end
            end
            x_in_data  = j.x[s];
            x_in_valid = 1'b1;
            chk("x_ready", int'(x_in_ready), 1);
            exp_q.push_back(j.e[s]);
            exp_cyc_q.push_back(cyc + NUM_PE + 2);
            tick();
            x_in_valid = 1'b0;
        end
        start      = 1'b0;
        w_in_valid = 1'b0;
        // Valid held high during DRAIN must not be accepted.
        x_in_valid = 1'b1;
        x_in_data  = 8'h77;
        chk("x_ready_after_stream", int'(x_in_ready), 0);
        for (int t = 0; t < 40 && done_cnt == 0; t++) tick();
        x_in_valid = 1'b0;
        chk("done_seen", done_cnt, 1);
        if (j.len > 0) chk("done_after_last_res", done_cyc, last_res_cyc + 1);
        chk("busy_fall", int'(busy), 0);
        chk("done_pulse_width", int'(done), 0);
        repeat (8) tick();
        chk("res_count", res_cnt, j.len);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 1);
    endtask

    // ---------------- test ----------------
    initial begin
        jobs[0] = '{load_w: 1'b1, len: 3, gap: 0, noise: 1'b0,
                    w: 32'h01010101, x: 32'h00070605, e: 32'h001C1814};
        jobs[1] = '{load_w: 1'b1, len: 3, gap: 2, noise: 1'b0,
                    w: 32'h01010101, x: 32'h00070605, e: 32'h001C1814};
        jobs[2] = '{load_w: 1'b0, len: 0, gap: 0, noise: 1'b0,
                    w: 32'h0, x: 32'h0, e: 32'h0};
        jobs[3] = '{load_w: 1'b1, len: 1, gap: 0, noise: 1'b0,
                    w: 32'h01000302, x: 32'h00000032, e: 32'h0000002C};
        jobs[4] = '{load_w: 1'b0, len: 2, gap: 0, noise: 1'b0,
                    w: 32'h0, x: 32'h0000640A, e: 32'h0000583C};
        jobs[5] = '{load_w: 1'b1, len: 4, gap: 1, noise: 1'b1,
                    w: 32'h030201FF, x: 32'h00C80403, e: 32'h00E8140F};

        reset      = 1'b1;
        start      = 1'b0;
        load_w     = 1'b0;
        len        = '0;
        w_in_data  = '0;
        w_in_valid = 1'b0;
        x_in_data  = '0;
        x_in_valid = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_sel", int'(pe_w_sel), 0);
        chk("rst_pe_x", int'(pe_x), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // Reset in the middle of STREAM, with start asserted together with reset.
        exp_q.delete();
        exp_cyc_q.delete();
        res_cnt  = 0;
        done_cnt = 0;
        start  = 1'b1;
        load_w = 1'b0;
        len    = 8'd4;
        tick();
        start      = 1'b0;
        x_in_data  = 8'd9;
        x_in_valid = 1'b1;
        tick();
        x_in_valid = 1'b0;
        chk("pre_reset_pe_x", int'(pe_x), 9);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("mid_rst_pe_w_sel", int'(pe_w_sel), 0);
        chk("mid_rst_pe_w_data", int'(pe_w_data), 0);
        chk("mid_rst_pe_x", int'(pe_x), 0);
        chk("mid_rst_pe_y", int'(pe_y), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_x_ready", int'(x_in_ready), 0);
        chk("mid_rst_w_ready", int'(w_in_ready), 0);
        repeat (12) tick();
        chk("post_rst_res_count", res_cnt, 0);
        chk("post_rst_done_count", done_cnt, 0);
        chk("post_rst_idle", int'(busy), 0);

        run_job(jobs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end
endmodule
